// File: rtl/vrf_pkg.sv
// Shared widths and payload types for the VRF write path.
package vrf_pkg;

  localparam int unsigned NUM_REG = 32;
  localparam int unsigned DATA_W  = 128;
  localparam int unsigned ADDR_W  = $clog2(NUM_REG);

  typedef logic [ADDR_W-1:0] vrf_addr_t;
  typedef logic [DATA_W-1:0] vrf_data_t;

  typedef struct packed {
    vrf_addr_t addr;
    vrf_data_t data;
  } wr_req_t;

endpackage

// File: rtl/vrf_req_fifo.sv
// In-order request FIFO with wrap-bit pointers; exposes per-entry valid and
// address so the parent can build a pending-register mask.
module vrf_req_fifo
  import vrf_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic                                  i_push,
  input  logic                                  i_pop,
  input  logic                                  i_flush,
  input  wr_req_t                               i_req,
  output wr_req_t                               o_head,
  output logic [$clog2(DEPTH):0]                o_count,
  output logic                                  o_full,
  output logic [DEPTH-1:0]                      o_valid,
  output logic [DEPTH-1:0][ADDR_W-1:0]          o_addr
);

  localparam int unsigned IDX_W = $clog2(DEPTH);
  localparam int unsigned PTR_W = IDX_W + 1;

  logic [PTR_W-1:0] r_wptr;
  logic [PTR_W-1:0] r_rptr;
  wr_req_t          r_mem [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else if (i_flush) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (i_push) r_wptr <= r_wptr + PTR_W'(1);
      if (i_pop)  r_rptr <= r_rptr + PTR_W'(1);
    end
  end

  // Payload storage needs no reset; occupancy is tracked by the pointers.
  always_ff @(posedge clk) begin
    if (i_push && !i_flush) r_mem[r_wptr[IDX_W-1:0]] <= i_req;
  end

  assign o_count = r_wptr - r_rptr;
  assign o_full  = (r_wptr[IDX_W] != r_rptr[IDX_W]) &&
                   (r_wptr[IDX_W-1:0] == r_rptr[IDX_W-1:0]);
  assign o_head  = r_mem[r_rptr[IDX_W-1:0]];

  // Slot j is occupied when its distance from the read pointer is below count.
  always_comb begin
    o_valid = '0;
    o_addr  = '0;
    for (int j = 0; j < int'(DEPTH); j++) begin
      o_valid[j] = {1'b0, IDX_W'(IDX_W'(j) - r_rptr[IDX_W-1:0])} < o_count;
      o_addr[j]  = r_mem[j].addr;
    end
  end

endmodule

// File: rtl/vrf_write_queue.sv
// VRF write-request queue: valid/ready intake, one registered write per cycle
// toward the decoder/bank, and a pending mask for read-side RAW detection.
module vrf_write_queue
  import vrf_pkg::ADDR_W, vrf_pkg::vrf_addr_t, vrf_pkg::vrf_data_t, vrf_pkg::wr_req_t;
#(
  parameter int unsigned NUM_REG = vrf_pkg::NUM_REG,
  parameter int unsigned DEPTH   = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  vrf_addr_t               req_addr,
  input  vrf_data_t               req_data,
  input  logic                    wr_hold,
  input  logic                    flush,
  output logic                    wr_en,
  output vrf_addr_t               wr_addr,
  output vrf_data_t               wr_data,
  output logic [NUM_REG-1:0]      pending_mask,
  output logic [$clog2(DEPTH):0]  count,
  output logic                    err_addr
);

  logic                         w_full;
  logic                         w_accept;
  logic                         w_in_range;
  logic                         w_push;
  logic                         w_pop;
  wr_req_t                      w_req;
  wr_req_t                      w_head;
  logic [DEPTH-1:0]             w_valid;
  logic [DEPTH-1:0][ADDR_W-1:0] w_addr;

  logic      r_wr_en;
  vrf_addr_t r_wr_addr;
  vrf_data_t r_wr_data;
  logic      r_err_addr;

  // Ready comes only from registered occupancy and the flush input.
  assign req_ready  = !w_full && !flush;
  assign w_accept   = req_valid && req_ready;
  assign w_in_range = 32'(req_addr) < NUM_REG;
  assign w_push     = w_accept && w_in_range;
  assign w_pop      = (count != '0) && !wr_hold && !flush;
  assign w_req      = '{addr: req_addr, data: req_data};

  vrf_req_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_flush (flush),
    .i_req   (w_req),
    .o_head  (w_head),
    .o_count (count),
    .o_full  (w_full),
    .o_valid (w_valid),
    .o_addr  (w_addr)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_en    <= 1'b0;
      r_wr_addr  <= '0;
      r_wr_data  <= '0;
      r_err_addr <= 1'b0;
    end else begin
      r_wr_en    <= w_pop;
      r_err_addr <= w_accept && !w_in_range;
      if (w_pop) begin
        r_wr_addr <= w_head.addr;
        r_wr_data <= w_head.data;
      end
    end
  end

  assign wr_en    = r_wr_en;
  assign wr_addr  = r_wr_addr;
  assign wr_data  = r_wr_data;
  assign err_addr = r_err_addr;

  // A register stays pending until its last write has left the output stage.
  always_comb begin
    pending_mask = '0;
    for (int i = 0; i < int'(NUM_REG); i++) begin
      if (r_wr_en && (r_wr_addr == ADDR_W'(i))) pending_mask[i] = 1'b1;
      for (int j = 0; j < int'(DEPTH); j++) begin
        if (w_valid[j] && (w_addr[j] == ADDR_W'(i))) pending_mask[i] = 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_vrf_write_queue.sv
// Directed bench for vrf_write_queue with NUM_REG=24, DEPTH=4.
module tb_vrf_write_queue;

  localparam int unsigned NUM_REG = 24;
  localparam int unsigned DEPTH   = 4;

  logic         clk;
  logic         rst_n;
  logic         req_valid;
  logic         req_ready;
  logic [4:0]   req_addr;
  logic [127:0] req_data;
  logic         wr_hold;
  logic         flush;
  logic         wr_en;
  logic [4:0]   wr_addr;
  logic [127:0] wr_data;
  logic [23:0]  pending_mask;
  logic [2:0]   count;
  logic         err_addr;

  int n_checks = 0;
  int n_fail   = 0;

  vrf_write_queue #(.NUM_REG(NUM_REG), .DEPTH(DEPTH)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_addr     (req_addr),
    .req_data     (req_data),
    .wr_hold      (wr_hold),
    .flush        (flush),
    .wr_en        (wr_en),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .pending_mask (pending_mask),
    .count        (count),
    .err_addr     (err_addr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [127:0] pat(input int unsigned k);
    return {4{32'hC0DE_0000 + k}};
  endfunction

  task automatic test_reset();
    rst_n = 1'b0; req_valid = 1'b0; req_addr = '0; req_data = '0;
    wr_hold = 1'b0; flush = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    tick();
    n_checks++;
    if ({wr_en, wr_addr, wr_data, err_addr, count} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got en=%0b addr=%0d data=%h err=%0b cnt=%0d exp all 0",
               wr_en, wr_addr, wr_data, err_addr, count);
    end
    n_checks++;
    if (req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %0b exp 1", req_ready); end
    n_checks++;
    if (pending_mask !== 24'h0) begin n_fail++; $display("FAIL reset_pending: got %h exp 0", pending_mask); end
  endtask

  task automatic test_single_write();
    req_valid = 1'b1; req_addr = 5'd5; req_data = {16{8'hA5}};
    tick();
    req_valid = 1'b0;
    n_checks++;
    if (wr_en !== 1'b0 || count !== 3'd1 || pending_mask !== 24'h000020) begin
      n_fail++;
      $display("FAIL single_accept: got en=%0b cnt=%0d pm=%h exp en=0 cnt=1 pm=000020",
               wr_en, count, pending_mask);
    end
    tick();
    n_checks++;
    if (wr_en !== 1'b1 || wr_addr !== 5'd5 || wr_data !== {16{8'hA5}}) begin
      n_fail++;
      $display("FAIL single_issue: got en=%0b addr=%0d data=%h exp en=1 addr=5 data=a5..",
               wr_en, wr_addr, wr_data);
    end
    n_checks++;
    if (pending_mask !== 24'h000020 || count !== 3'd0) begin
      n_fail++;
      $display("FAIL single_pending_issue: got pm=%h cnt=%0d exp pm=000020 cnt=0", pending_mask, count);
    end
    tick();
    n_checks++;
    if (wr_en !== 1'b0 || pending_mask !== 24'h0 || wr_addr !== 5'd5) begin
      n_fail++;
      $display("FAIL single_done: got en=%0b pm=%h addr=%0d exp en=0 pm=0 addr=5", wr_en, pending_mask, wr_addr);
    end
  endtask

  task automatic test_fill_drain();
    logic [4:0] exp_addr [5];
    logic [2:0] exp_cnt  [5];
    exp_addr = '{5'd1, 5'd2, 5'd3, 5'd4, 5'd7};
    exp_cnt  = '{3'd3, 3'd3, 3'd2, 3'd1, 3'd0};
    wr_hold = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      req_valid = 1'b1; req_addr = 5'(i); req_data = pat(i);
      tick();
    end
    req_addr = 5'd9; req_data = pat(9);
    tick();
    n_checks++;
    if (count !== 3'd4 || req_ready !== 1'b0 || pending_mask !== 24'h00001E || wr_en !== 1'b0) begin
      n_fail++;
      $display("FAIL fill_full: got cnt=%0d rdy=%0b pm=%h en=%0b exp cnt=4 rdy=0 pm=00001e en=0",
               count, req_ready, pending_mask, wr_en);
    end
    // Release hold while a request waits on the full queue: it must miss this edge.
    wr_hold = 1'b0; req_addr = 5'd7; req_data = pat(7);
    for (int i = 0; i < 5; i++) begin
      tick();
      if (i == 1) req_valid = 1'b0;
      n_checks++;
      if (wr_en !== 1'b1 || wr_addr !== exp_addr[i] || wr_data !== pat(exp_addr[i]) || count !== exp_cnt[i]) begin
        n_fail++;
        $display("FAIL drain_%0d: got en=%0b addr=%0d cnt=%0d exp en=1 addr=%0d cnt=%0d",
                 i, wr_en, wr_addr, count, exp_addr[i], exp_cnt[i]);
      end
    end
    tick();
    n_checks++;
    if (wr_en !== 1'b0 || pending_mask !== 24'h0) begin
      n_fail++;
      $display("FAIL drain_idle: got en=%0b pm=%h exp en=0 pm=0", wr_en, pending_mask);
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 10; i++) begin
      req_valid = 1'b1; req_addr = 5'(i + 10); req_data = pat(100 + i);
      tick();
      n_checks++;
      if (count !== 3'd1) begin n_fail++; $display("FAIL b2b_count_%0d: got %0d exp 1", i, count); end
      if (i > 0) begin
        n_checks++;
        if (wr_en !== 1'b1 || wr_addr !== 5'(i + 9) || wr_data !== pat(99 + i)) begin
          n_fail++;
          $display("FAIL b2b_write_%0d: got en=%0b addr=%0d exp en=1 addr=%0d", i, wr_en, wr_addr, i + 9);
        end
      end
    end
    req_valid = 1'b0;
    tick();
    n_checks++;
    if (wr_en !== 1'b1 || wr_addr !== 5'd19 || wr_data !== pat(109) || count !== 3'd0) begin
      n_fail++;
      $display("FAIL b2b_last: got en=%0b addr=%0d cnt=%0d exp en=1 addr=19 cnt=0", wr_en, wr_addr, count);
    end
    tick();
    n_checks++;
    if (wr_en !== 1'b0) begin n_fail++; $display("FAIL b2b_idle: got en=%0b exp 0", wr_en); end
  endtask

  task automatic test_flush();
    wr_hold = 1'b1;
    for (int i = 10; i < 14; i++) begin
      req_valid = 1'b1; req_addr = 5'(i); req_data = pat(i);
      tick();
    end
    req_valid = 1'b0; wr_hold = 1'b0;
    tick();
    n_checks++;
    if (count !== 3'd3 || wr_en !== 1'b1 || wr_addr !== 5'd10) begin
      n_fail++;
      $display("FAIL flush_pre: got cnt=%0d en=%0b addr=%0d exp cnt=3 en=1 addr=10", count, wr_en, wr_addr);
    end
    flush = 1'b1; req_valid = 1'b1; req_addr = 5'd20;
    #1;
    n_checks++;
    if (req_ready !== 1'b0) begin n_fail++; $display("FAIL flush_ready: got %0b exp 0", req_ready); end
    tick();
    flush = 1'b0; req_valid = 1'b0;
    n_checks++;
    if (count !== 3'd0 || wr_en !== 1'b0 || pending_mask !== 24'h0 || wr_addr !== 5'd10) begin
      n_fail++;
      $display("FAIL flush_after: got cnt=%0d en=%0b pm=%h addr=%0d exp cnt=0 en=0 pm=0 addr=10",
               count, wr_en, pending_mask, wr_addr);
    end
    tick();
    n_checks++;
    if (count !== 3'd0 || wr_en !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_quiet: got cnt=%0d en=%0b exp cnt=0 en=0", count, wr_en);
    end
  endtask

  task automatic test_bad_addr();
    req_valid = 1'b1; req_addr = 5'd30; req_data = pat(30);
    #1;
    n_checks++;
    if (req_ready !== 1'b1) begin n_fail++; $display("FAIL bad_ready: got %0b exp 1", req_ready); end
    tick();
    n_checks++;
    if (err_addr !== 1'b1 || count !== 3'd0 || pending_mask !== 24'h0) begin
      n_fail++;
      $display("FAIL bad_30: got err=%0b cnt=%0d pm=%h exp err=1 cnt=0 pm=0", err_addr, count, pending_mask);
    end
    req_addr = 5'd24;
    tick();
    n_checks++;
    if (err_addr !== 1'b1 || count !== 3'd0 || wr_en !== 1'b0) begin
      n_fail++;
      $display("FAIL bad_24: got err=%0b cnt=%0d en=%0b exp err=1 cnt=0 en=0", err_addr, count, wr_en);
    end
    req_addr = 5'd23; req_data = pat(23);
    tick();
    req_valid = 1'b0;
    n_checks++;
    if (err_addr !== 1'b0 || count !== 3'd1 || pending_mask !== 24'h800000) begin
      n_fail++;
      $display("FAIL edge_23: got err=%0b cnt=%0d pm=%h exp err=0 cnt=1 pm=800000", err_addr, count, pending_mask);
    end
    tick();
    n_checks++;
    if (wr_en !== 1'b1 || wr_addr !== 5'd23 || err_addr !== 1'b0) begin
      n_fail++;
      $display("FAIL edge_23_issue: got en=%0b addr=%0d err=%0b exp en=1 addr=23 err=0", wr_en, wr_addr, err_addr);
    end
    tick();
  endtask

  task automatic test_async_reset();
    wr_hold = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      req_valid = 1'b1; req_addr = 5'(i); req_data = pat(i);
      tick();
    end
    req_valid = 1'b0; wr_hold = 1'b0;
    tick(); tick();
    n_checks++;
    if (wr_en !== 1'b1 || count !== 3'd2 || wr_addr !== 5'd2) begin
      n_fail++;
      $display("FAIL arst_pre: got en=%0b cnt=%0d addr=%0d exp en=1 cnt=2 addr=2", wr_en, count, wr_addr);
    end
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({wr_en, wr_addr, wr_data, count, err_addr} !== '0 || pending_mask !== 24'h0 || req_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL arst_now: got en=%0b addr=%0d cnt=%0d pm=%h rdy=%0b exp all 0 rdy=1",
               wr_en, wr_addr, count, pending_mask, req_ready);
    end
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++;
      if (wr_en !== 1'b0 || count !== 3'd0) begin
        n_fail++;
        $display("FAIL arst_stale_%0d: got en=%0b cnt=%0d exp en=0 cnt=0", i, wr_en, count);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_fill_drain();
    test_back_to_back();
    test_flush();
    test_bad_addr();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
